fir_filter_param: RTL and testbench
===================================

# fir_filter_param

Parametrised, time-multiplexed FIR filter with a programmable tap count and data/coefficient widths, a configurable output-count pulse and a saturating magnitude output. It generalises the existing fixed four-tap `fir_filter` top level. The two handshake inputs are synchronised internally, the filter runs one multiply-accumulate per clock, and it exposes the same `modwait` / `err` / `one_k_samples` status outputs to the surrounding AHB-side wrapper.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed two's complement; also the `fir_out` width (unsigned).
- `COEFF_W`, 16: coefficient width, signed Q1.(COEFF_W-1).
- `NUM_TAPS`, 4: number of taps, 2..32.
- `SAMPLE_CNT`, 1000: number of completed outputs per `one_k_samples` pulse, ≥1.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_ready`  in  1: asynchronous. A rising edge requests processing of `sample_data`.
- `load_coeff`  in  1: asynchronous. A rising edge loads `fir_coefficient` into the next tap slot.
- `sample_data`  in  DATA_W: new sample. Held stable by the source while `data_ready` is high.
- `fir_coefficient`  in  COEFF_W: coefficient. Held stable by the source while `load_coeff` is high.
- `fir_out`  out  DATA_W: saturated magnitude of the latest filter result.
- `modwait`  out  1: high while the filter is busy.
- `err`  out  1: sticky error flag.
- `one_k_samples`  out  1: one-cycle pulse after every SAMPLE_CNT completed outputs.

## Operation
- Input conditioning
  - `data_ready` and `load_coeff` each pass through a two-flop synchroniser (reset to 0).
  - An event `dr_ev` / `lc_ev` is a single-cycle rising edge of the synchronised level.
- State machine: IDLE, MAC, DONE. Reset state is IDLE.
- IDLE
  - On `dr_ev`: shift `sample_data` into delay line position 0, shift older samples up one position, discard the oldest, clear the accumulator, tap index k = 0, go to MAC.
  - On `lc_ev`: write coeff[cidx], then cidx = (cidx+1) mod NUM_TAPS (wrap-around).
  - Simultaneous `dr_ev` and `lc_ev`: both actions are performed. The new sample is processed using the old coefficient at cidx.
- MAC (NUM_TAPS cycles)
  - Each cycle: acc += sample[k] * coeff[k], then k++.
  - Leave for DONE after k = NUM_TAPS-1.
- DONE (one cycle)
  - Register `fir_out`.
  - Increment the output counter.
  - Return to IDLE.
- Arithmetic
  - Accumulator is signed, width DATA_W+COEFF_W+clog2(NUM_TAPS).
  - Result r = acc >>> (COEFF_W-1), arithmetic shift with truncation toward −∞.
  - `fir_out` = min(|r|, 2^DATA_W − 1).
  - If the clamp engages, set `err`.
- Busy violations: `dr_ev` or `lc_ev` arriving in MAC or DONE is dropped, and `err` is set.
- `err` clears on the next DONE cycle that completes without saturation. If both a set and a clear condition occur in the same cycle, set wins.
- Output counter
  - Counts 0..SAMPLE_CNT-1.
  - When the count reaches SAMPLE_CNT it wraps to 0 and `one_k_samples` pulses in the following cycle.
- Reset, asserted at any time including mid-MAC:
  - State → IDLE.
  - Delay line, coefficients, cidx, accumulator and output counter → 0.
  - Outputs `fir_out`=0, `modwait`=0, `err`=0, `one_k_samples`=0.

## Timing
- Raw `data_ready` rises before clock edge E0: synchronised level high after E1, so `dr_ev` is high in the cycle following E1.
- The edge at the end of the `dr_ev` cycle (E2) enters MAC. `modwait` is registered and goes high after E2.
- MAC occupies NUM_TAPS cycles, followed by DONE.
- `fir_out` and `err` update, and `modwait` falls, at the same edge: E2+NUM_TAPS+1.
- `modwait` is high for exactly NUM_TAPS+1 cycles per sample.
- Coefficient write takes effect at the edge ending the `lc_ev` cycle (E2 relative to raw `load_coeff`).
- A new `data_ready` edge is accepted as soon as `modwait` is low. The next `dr_ev` may coincide with the first IDLE cycle.
- `one_k_samples` is high for exactly one cycle, one cycle after the DONE that wraps the counter.

## Test plan
Use NUM_TAPS=4, DATA_W=COEFF_W=16, SAMPLE_CNT=5 unless stated otherwise.
- **Reset:** assert `rst` mid-MAC → all outputs 0 immediately, asynchronously. After release, the first result uses zeroed history and coefficients, so `fir_out`=0.
- **Basic filter:** load four coefficients 0x4000, then send samples 100 four times. Required `fir_out` sequence 50, 100, 150, 200. `modwait` is high for 5 cycles each time, and `err` stays 0.
- **Negative input and magnitude:** coefficients {0x4000, 0, 0, 0}, sample 0xFED4 (−300) → `fir_out`=150, `err`=0.
- **Saturation:** all coefficients 0x7FFF and four samples 0x7FFF → `fir_out`=0xFFFF and `err`=1. Then zero the coefficients and send one sample → `fir_out`=0 and `err` clears.
- **Busy violation:** `data_ready` edge 2 cycles into MAC → that sample is dropped (delay line unchanged) and `err`=1. Same check for `load_coeff` during MAC: coefficients are unchanged and cidx does not advance.
- **Counter and wrap:** five processed samples → `one_k_samples` is a single-cycle pulse after the 5th DONE, and the counter wraps. A fifth `load_coeff` overwrites coeff[0].

Source files
------------

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - time-multiplexed FIR filter, one MAC per clock, saturating magnitude output
module fir_filter_param #(
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 16,
  parameter int NUM_TAPS   = 4,
  parameter int SAMPLE_CNT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_ready,
  input  logic               load_coeff,
  input  logic [DATA_W-1:0]  sample_data,
  input  logic [COEFF_W-1:0] fir_coefficient,
  output logic [DATA_W-1:0]  fir_out,
  output logic               modwait,
  output logic               err,
  output logic               one_k_samples
);

  localparam int KW    = $clog2(NUM_TAPS);
  localparam int PW    = DATA_W + COEFF_W;
  localparam int ACC_W = PW + KW;
  localparam int CNT_W = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;

  localparam logic [KW-1:0]    K_LAST   = KW'(NUM_TAPS - 1);
  localparam logic [KW-1:0]    K_ONE    = KW'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state_q, state_d;

  logic dr_s1_q, dr_s2_q, dr_s3_q;
  logic lc_s1_q, lc_s2_q, lc_s3_q;
  logic dr_ev, lc_ev;

  logic signed [DATA_W-1:0]  samples_q [NUM_TAPS];
  logic signed [COEFF_W-1:0] coeffs_q  [NUM_TAPS];

  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            cidx_q, cidx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        fir_out_q, fir_out_d;
  logic                     err_q, err_d;
  logic                     one_k_q, one_k_d;

  // A coefficient arriving together with a sample is parked until DONE so
  // the sample in flight still sees the old coefficient at that slot.
  logic                     pend_vld_q;
  logic [KW-1:0]            pend_idx_q;
  logic [COEFF_W-1:0]       pend_coeff_q;

  logic                     shift_en, cwr_en, pend_set, pend_apply;
  logic                     err_set, err_clr;

  logic signed [PW-1:0]     prod;
  logic [ACC_W-1:0]         prod_ext;
  logic signed [ACC_W-1:0]  res;
  logic [ACC_W-1:0]         mag;
  logic                     sat;

  assign dr_ev = dr_s2_q & ~dr_s3_q;
  assign lc_ev = lc_s2_q & ~lc_s3_q;

  assign prod     = samples_q[k_q] * coeffs_q[k_q];
  assign prod_ext = {{KW{prod[PW-1]}}, prod};
  assign res      = acc_q >>> (COEFF_W - 1);
  assign mag      = res[ACC_W-1] ? -res : res;
  assign sat      = |mag[ACC_W-1:DATA_W];

  assign fir_out       = fir_out_q;
  assign modwait       = (state_q != IDLE);
  assign err           = err_q;
  assign one_k_samples = one_k_q;

  // Two-flop synchronisers followed by one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_s1_q <= 1'b0; dr_s2_q <= 1'b0; dr_s3_q <= 1'b0;
      lc_s1_q <= 1'b0; lc_s2_q <= 1'b0; lc_s3_q <= 1'b0;
    end else begin
      dr_s1_q <= data_ready; dr_s2_q <= dr_s1_q; dr_s3_q <= dr_s2_q;
      lc_s1_q <= load_coeff; lc_s2_q <= lc_s1_q; lc_s3_q <= lc_s2_q;
    end
  end

  // Next-state, accumulator, counter and flag logic
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    cidx_d     = cidx_q;
    cnt_d      = cnt_q;
    fir_out_d  = fir_out_q;
    one_k_d    = 1'b0;
    shift_en   = 1'b0;
    cwr_en     = 1'b0;
    pend_set   = 1'b0;
    pend_apply = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lc_ev) begin
          cidx_d = (cidx_q == K_LAST) ? '0 : cidx_q + K_ONE;
          if (dr_ev) pend_set = 1'b1;
          else       cwr_en   = 1'b1;
        end
        if (dr_ev) begin
          shift_en = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d   = acc_q + prod_ext;
        k_d     = k_q + K_ONE;
        err_set = dr_ev | lc_ev;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        fir_out_d  = sat ? '1 : mag[DATA_W-1:0];
        err_set    = dr_ev | lc_ev | sat;
        err_clr    = ~sat;
        pend_apply = pend_vld_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          one_k_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      cidx_q    <= '0;
      cnt_q     <= '0;
      fir_out_q <= '0;
      err_q     <= 1'b0;
      one_k_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      cidx_q    <= cidx_d;
      cnt_q     <= cnt_d;
      fir_out_q <= fir_out_d;
      err_q     <= err_d;
      one_k_q   <= one_k_d;
    end
  end

  // Delay line, coefficient bank and deferred coefficient write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        samples_q[i] <= '0;
        coeffs_q[i]  <= '0;
      end
      pend_vld_q   <= 1'b0;
      pend_idx_q   <= '0;
      pend_coeff_q <= '0;
    end else begin
      if (shift_en) begin
        samples_q[0] <= sample_data;
        for (int i = 1; i < NUM_TAPS; i++) samples_q[i] <= samples_q[i-1];
      end
      if (cwr_en) coeffs_q[cidx_q] <= fir_coefficient;
      if (pend_set) begin
        pend_vld_q   <= 1'b1;
        pend_idx_q   <= cidx_q;
        pend_coeff_q <= fir_coefficient;
      end else if (pend_apply) begin
        pend_vld_q             <= 1'b0;
        coeffs_q[pend_idx_q]   <= pend_coeff_q;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - self-checking bench for fir_filter_param against an arithmetic model
module tb_fir_filter_param;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam int SC = 5;
  localparam longint MAXO = (longint'(1) << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_ready = 1'b0;
  logic          load_coeff = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [CW-1:0] fir_coefficient = '0;
  logic [DW-1:0] fir_out;
  logic          modwait;
  logic          err;
  logic          one_k_samples;

  int n_assert = 0;
  int n_fail   = 0;

  longint m_hist [NT];
  longint m_coef [NT];
  int     m_cidx;
  int     m_cnt;
  bit     m_err;

  fir_filter_param #(
    .DATA_W(DW), .COEFF_W(CW), .NUM_TAPS(NT), .SAMPLE_CNT(SC)
  ) dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .load_coeff(load_coeff),
    .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .fir_out(fir_out), .modwait(modwait), .err(err), .one_k_samples(one_k_samples)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 0;
    end
    m_cidx = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_coeff(input logic [CW-1:0] v);
    m_coef[m_cidx] = longint'($signed(v));
    m_cidx = (m_cidx + 1) % NT;
  endtask

  task automatic model_sample(input logic [DW-1:0] v, output longint exp, output bit wrap);
    longint acc, r, mag;
    bit sat;
    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = longint'($signed(v));
    acc = 0;
    for (int i = 0; i < NT; i++) acc += m_hist[i] * m_coef[i];
    r   = acc >>> (CW - 1);
    mag = (r < 0) ? -r : r;
    sat = (mag > MAXO);
    exp = sat ? MAXO : mag;
    m_err = sat;
    m_cnt = (m_cnt + 1) % SC;
    wrap  = (m_cnt == 0);
  endtask

  task automatic do_coeff(input logic [CW-1:0] v);
    @(negedge clk);
    fir_coefficient = v;
    load_coeff = 1'b1;
    repeat (4) @(negedge clk);
    load_coeff = 1'b0;
    repeat (3) @(negedge clk);
    model_coeff(v);
  endtask

  // inject: 0 none, 1 data_ready during MAC, 2 load_coeff during MAC, 3 load_coeff together with data_ready
  task automatic run_sample(input string tag, input logic [DW-1:0] v, input int inject, input logic [CW-1:0] cv);
    longint exp;
    bit wrap, seen;
    int cyc, hi;
    @(negedge clk);
    sample_data = v;
    data_ready  = 1'b1;
    if (inject == 3) begin
      fir_coefficient = cv;
      load_coeff = 1'b1;
    end
    cyc = 0;
    while (!modwait && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(3));
    data_ready = 1'b0;
    load_coeff = 1'b0;
    hi = 0;
    seen = 1'b0;
    while (modwait && hi < 50) begin
      if (hi == 1 && inject == 1) begin
        data_ready  = 1'b1;
        sample_data = 16'($urandom);
      end
      if (hi == 1 && inject == 2) begin
        load_coeff      = 1'b1;
        fir_coefficient = 16'($urandom);
      end
      @(negedge clk);
      hi++;
      if (err === 1'b1) seen = 1'b1;
    end
    model_sample(v, exp, wrap);
    if (inject == 3) model_coeff(cv);
    check({tag, "_busy_len"}, 64'(hi), 64'(NT + 1));
    check({tag, "_fir_out"}, 64'(fir_out), 64'(exp));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_one_k"}, 64'(one_k_samples), 64'(wrap));
    if (inject == 1 || inject == 2) check({tag, "_err_on_violation"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({tag, "_one_k_off"}, 64'(one_k_samples), 64'(0));
    data_ready = 1'b0;
    load_coeff = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int cyc;
    model_reset();

    // Reset state
    #1;
    check("rst_fir_out", 64'(fir_out), 64'(0));
    check("rst_modwait", 64'(modwait), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_one_k", 64'(one_k_samples), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic filter: four taps of 0.5, constant input 100
    for (int i = 0; i < NT; i++) do_coeff(16'h4000);
    for (int i = 0; i < 4; i++) begin
      run_sample("basic", 16'd100, 0, '0);
      check("basic_lit", 64'(fir_out), 64'(50 * (i + 1)));
    end

    // Negative input, magnitude output; fifth load wraps to coeff[0]
    do_coeff(16'h4000);
    do_coeff(16'h0000);
    do_coeff(16'h0000);
    do_coeff(16'h0000);
    run_sample("neg", 16'hFED4, 0, '0);
    check("neg_lit", 64'(fir_out), 64'(150));

    // Saturation then recovery
    for (int i = 0; i < NT; i++) do_coeff(16'h7FFF);
    for (int i = 0; i < 4; i++) run_sample("sat", 16'h7FFF, 0, '0);
    check("sat_lit", 64'(fir_out), 64'(16'hFFFF));
    check("sat_err_lit", 64'(err), 64'(1));
    for (int i = 0; i < NT; i++) do_coeff(16'h0000);
    run_sample("unsat", 16'h1234, 0, '0);
    check("unsat_lit", 64'(fir_out), 64'(0));
    check("unsat_err_lit", 64'(err), 64'(0));

    // Busy violations: dropped events must leave history and coefficients alone
    for (int i = 0; i < NT; i++) do_coeff(16'($urandom_range(0, 16'h3FFF)));
    run_sample("busy_pre", 16'($urandom), 0, '0);
    run_sample("busy_dr", 16'($urandom), 1, '0);
    run_sample("busy_dr_after", 16'($urandom), 0, '0);
    run_sample("busy_lc", 16'($urandom), 2, '0);
    do_coeff(16'($urandom_range(0, 16'h3FFF)));
    run_sample("busy_lc_after", 16'($urandom), 0, '0);

    // Simultaneous sample and coefficient: sample uses the old coefficient
    run_sample("simul", 16'($urandom), 3, 16'($urandom_range(0, 16'h3FFF)));
    run_sample("simul_after", 16'($urandom), 0, '0);

    // Randomized mix of loads and samples
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) do_coeff(16'($urandom));
      else run_sample("rand", 16'($urandom), 0, '0);
    end
    run_sample("rand_last", 16'($urandom), 0, '0);

    // Asynchronous reset in the middle of MAC
    @(negedge clk);
    sample_data = 16'h7000;
    data_ready  = 1'b1;
    cyc = 0;
    while (!modwait && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midmac_start", 64'(modwait), 64'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midmac_rst_fir_out", 64'(fir_out), 64'(0));
    check("midmac_rst_modwait", 64'(modwait), 64'(0));
    check("midmac_rst_err", 64'(err), 64'(0));
    check("midmac_rst_one_k", 64'(one_k_samples), 64'(0));
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    run_sample("post_rst", 16'($urandom), 0, '0);
    check("post_rst_lit", 64'(fir_out), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
